// File: rtl/pwl_activation_pipe.sv
// pwl_activation_pipe
// Multi-lane, mode-selectable piecewise-linear activation unit.
// Each beat carries pLANES signed fixed-point words. A per-beat mode selects
// bypass, ReLU, sigmoid or tanh. The sigmoid uses the four-segment PLAN
// approximation on |x|. Negative inputs are folded back afterwards, so the
// tanh output is exactly odd-symmetric.
// The three register stages shift together under a single advance condition.
// A stalled output therefore freezes the whole pipe and back-pressures the
// upstream producer through in_ready.

module pwl_activation_pipe #(
    parameter int pDATA_WIDTH = 32,
    parameter int pFRAC_NUM   = 16,
    parameter int pLANES      = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [1:0]                      mode,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [pLANES*pDATA_WIDTH-1:0]   data_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [pLANES*pDATA_WIDTH-1:0]   data_out
);

    localparam int W = pDATA_WIDTH;
    localparam int F = pFRAC_NUM;

    typedef logic [W-1:0] word_t;

    typedef enum logic [1:0] {
        MODE_BYPASS  = 2'b00,
        MODE_RELU    = 2'b01,
        MODE_SIGMOID = 2'b10,
        MODE_TANH    = 2'b11
    } mode_e;

    // Saturation limits of the signed word
    localparam word_t MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam word_t MIN_NEG = {1'b1, {(W-1){1'b0}}};
    // Magnitudes at or above this value overflow when doubled for tanh
    localparam word_t DOUBLE_LIMIT = word_t'(1) << (W - 2);

    // PLAN breakpoints and offsets, expressed in the fixed-point format
    localparam word_t ONE      = word_t'(1)  << F;        // 1.0
    localparam word_t HALF     = word_t'(1)  << (F - 1);  // 0.5
    localparam word_t SAT_KNEE = word_t'(5)  << F;        // 5.0
    localparam word_t MID_KNEE = word_t'(19) << (F - 3);  // 2.375
    localparam word_t C_HIGH   = word_t'(27) << (F - 5);  // 0.84375
    localparam word_t C_MID    = word_t'(5)  << (F - 3);  // 0.625

    // Stage 1 registers: sign, PLAN input magnitude, raw word, mode
    logic  s1_valid;
    mode_e s1_mode;
    logic  s1_sign [pLANES];
    word_t s1_mag  [pLANES];
    word_t s1_raw  [pLANES];

    // Stage 2 registers: PLAN offset (a) and slope term (b)
    logic  s2_valid;
    mode_e s2_mode;
    logic  s2_sign [pLANES];
    word_t s2_a    [pLANES];
    word_t s2_b    [pLANES];
    word_t s2_raw  [pLANES];

    // Next-state values produced by each stage's combinational logic
    logic  s1_sign_d [pLANES];
    word_t s1_mag_d  [pLANES];
    word_t s1_raw_d  [pLANES];
    word_t s2_a_d    [pLANES];
    word_t s2_b_d    [pLANES];
    logic [pLANES*W-1:0] result_d;

    logic adv;

    // The pipe moves whenever the output slot is empty or being drained
    always_comb begin : advance_logic
        adv      = !out_valid || out_ready;
        in_ready = adv;
    end

    // Stage 1 logic: split each lane into sign and magnitude.
    // The most negative word has no positive twin, so its magnitude saturates.
    // Tanh works on 2x: the doubled magnitude saturates to the largest positive word.
    always_comb begin : stage1_comb
        word_t x_v;
        word_t abs_v;
        x_v   = '0;
        abs_v = '0;
        for (int k = 0; k < pLANES; k++) begin
            x_v   = data_in[k*W +: W];
            if (x_v == MIN_NEG) begin
                abs_v = MAX_POS;
            end else if (x_v[W-1]) begin
                abs_v = -x_v;
            end else begin
                abs_v = x_v;
            end
            s1_raw_d[k]  = x_v;
            s1_sign_d[k] = x_v[W-1];
            if (mode_e'(mode) == MODE_TANH) begin
                s1_mag_d[k] = (abs_v >= DOUBLE_LIMIT) ? MAX_POS : (abs_v << 1);
            end else begin
                s1_mag_d[k] = abs_v;
            end
        end
    end

    // Stage 1 register: capture the accepted beat together with its mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_BYPASS;
            for (int k = 0; k < pLANES; k++) begin
                s1_sign[k] <= 1'b0;
                s1_mag[k]  <= '0;
                s1_raw[k]  <= '0;
            end
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_mode  <= mode_e'(mode);
            for (int k = 0; k < pLANES; k++) begin
                s1_sign[k] <= s1_sign_d[k];
                s1_mag[k]  <= s1_mag_d[k];
                s1_raw[k]  <= s1_raw_d[k];
            end
        end
    end

    // Stage 2 logic: choose the PLAN segment from the magnitude.
    // Each segment is a constant offset plus a right-shifted magnitude.
    always_comb begin : stage2_comb
        for (int k = 0; k < pLANES; k++) begin
            s2_a_d[k] = HALF;
            s2_b_d[k] = s1_mag[k] >> 2;
            if (s1_mag[k] >= SAT_KNEE) begin
                s2_a_d[k] = ONE;
                s2_b_d[k] = '0;
            end else if (s1_mag[k] >= MID_KNEE) begin
                s2_a_d[k] = C_HIGH;
                s2_b_d[k] = s1_mag[k] >> 5;
            end else if (s1_mag[k] >= ONE) begin
                s2_a_d[k] = C_MID;
                s2_b_d[k] = s1_mag[k] >> 3;
            end
        end
    end

    // Stage 2 register: hold the segment terms and forward sign, raw word and mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_mode  <= MODE_BYPASS;
            for (int k = 0; k < pLANES; k++) begin
                s2_sign[k] <= 1'b0;
                s2_a[k]    <= '0;
                s2_b[k]    <= '0;
                s2_raw[k]  <= '0;
            end
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_mode  <= s1_mode;
            for (int k = 0; k < pLANES; k++) begin
                s2_sign[k] <= s1_sign[k];
                s2_a[k]    <= s2_a_d[k];
                s2_b[k]    <= s2_b_d[k];
                s2_raw[k]  <= s1_raw[k];
            end
        end
    end

    // Stage 3 logic: add the segment terms and fold the sign back in.
    // For negative x the sigmoid becomes 1 - y+. Tanh is 2*y+ - 1,
    // negated for negative x, which is the same as 2*sigmoid(2x) - 1.
    always_comb begin : stage3_comb
        word_t yp_v;
        word_t t_v;
        result_d = '0;
        yp_v     = '0;
        t_v      = '0;
        for (int k = 0; k < pLANES; k++) begin
            yp_v = s2_a[k] + s2_b[k];
            t_v  = (yp_v << 1) - ONE;
            case (s2_mode)
                MODE_BYPASS:  result_d[k*W +: W] = s2_raw[k];
                MODE_RELU:    result_d[k*W +: W] = s2_sign[k] ? '0 : s2_raw[k];
                MODE_SIGMOID: result_d[k*W +: W] = s2_sign[k] ? (ONE - yp_v) : yp_v;
                MODE_TANH:    result_d[k*W +: W] = s2_sign[k] ? (-t_v) : t_v;
                default:      result_d[k*W +: W] = s2_raw[k];
            endcase
        end
    end

    // Stage 3 register: present the result; bubbles leave the last data in place
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                data_out <= result_d;
            end
        end
    end

endmodule
